// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and FSM encodings,
// default latencies and opcode classification helpers.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned CNT_W            = 4;
    localparam int unsigned MULT_CYCLES_DEF  = 5;
    localparam int unsigned DIV_CYCLES_DEF   = 10;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the multiplier latency window
    function automatic logic is_mult_op(input mdu_op_e op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    // Ops that occupy the divider latency window
    function automatic logic is_div_op(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for the multiply/divide unit.
// Produces the {HI,LO} pair an operation will commit, plus a divide-by-zero flag.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract).
module mdu_calc
    import mdu_pkg::*;
(
    input  mdu_op_e           op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [XLEN-1:0]   hi_i,
    input  logic [XLEN-1:0]   lo_i,
    output logic [XLEN-1:0]   phi_o,
    output logic [XLEN-1:0]   plo_o,
    output logic              div0_o
);

    logic [2*XLEN-1:0]        prod_s;
    logic [2*XLEN-1:0]        prod_u;
    logic [XLEN-1:0]          divisor;
    logic signed [XLEN-1:0]   sq;
    logic signed [XLEN-1:0]   sr;
    logic [XLEN-1:0]          uq;
    logic [XLEN-1:0]          ur;
    logic                     sdiv_ovf;

    // Products, quotients and final result selection
    always_comb begin
        prod_s   = {{XLEN{a_i[XLEN-1]}}, a_i} * {{XLEN{b_i[XLEN-1]}}, b_i};
        prod_u   = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};
        div0_o   = (b_i == '0);
        // Substitute a harmless divisor so the dividers never see zero
        divisor  = div0_o ? XLEN'(1) : b_i;
        // Most-negative / -1 wraps to itself with zero remainder
        sdiv_ovf = (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
        sq       = $signed(a_i) / $signed(divisor);
        sr       = $signed(a_i) % $signed(divisor);
        uq       = a_i / divisor;
        ur       = a_i % divisor;
        phi_o    = hi_i;
        plo_o    = lo_i;
        case (op_i)
            OP_MULT:  {phi_o, plo_o} = prod_s;
            OP_MULTU: {phi_o, plo_o} = prod_u;
            OP_DIV: begin
                if (!div0_o) begin
                    if (sdiv_ovf) begin
                        plo_o = a_i;
                        phi_o = '0;
                    end else begin
                        plo_o = sq;
                        phi_o = sr;
                    end
                end
            end
            OP_DIVU: begin
                if (!div0_o) begin
                    plo_o = uq;
                    phi_o = ur;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {phi_o, plo_o} = {hi_i, lo_i} + prod_s;
            OP_MADDU: {phi_o, plo_o} = {hi_i, lo_i} + prod_u;
            OP_MSUB:  {phi_o, plo_o} = {hi_i, lo_i} - prod_s;
            OP_MSUBU: {phi_o, plo_o} = {hi_i, lo_i} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit top: sequencing FSM, latency counter, pending result
// registers and the architectural HI/LO pair. Results commit at the end of a
// fixed busy window; mfhi/mflo read the committed HI/LO combinationally.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract opcodes).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [3:0]        MDUOp,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    input  logic              Req,
    output logic              Busy,
    output logic [XLEN-1:0]   HI,
    output logic [XLEN-1:0]   LO,
    output logic [XLEN-1:0]   MDU_Result
);

    mdu_op_e              op;
    mdu_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic [XLEN-1:0]      hi_q;
    logic [XLEN-1:0]      lo_q;
    logic [XLEN-1:0]      phi_q;
    logic [XLEN-1:0]      plo_q;
    logic                 div0_q;
    logic [XLEN-1:0]      calc_phi;
    logic [XLEN-1:0]      calc_plo;
    logic                 calc_div0;
    logic                 launch;

    assign op     = mdu_op_e'(MDUOp);
    assign launch = Start && !Req && (is_mult_op(op) || is_div_op(op));

    mdu_calc u_calc (
        .op_i   (op),
        .a_i    (A),
        .b_i    (B),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .phi_o  (calc_phi),
        .plo_o  (calc_plo),
        .div0_o (calc_div0)
    );

    // Sequencing FSM: launch, count down the busy window, commit to HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= is_div_op(op) ? CNT_W'(DIV_CYCLES)
                                                 : CNT_W'(MULT_CYCLES);
                        phi_q   <= calc_phi;
                        plo_q   <= calc_plo;
                        div0_q  <= calc_div0 && is_div_op(op);
                    end else if (!Req && op == OP_MTHI) begin
                        hi_q <= A;
                    end else if (!Req && op == OP_MTLO) begin
                        lo_q <= A;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (!div0_q) begin
                            hi_q <= phi_q;
                            lo_q <= plo_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // mfhi/mflo read port, no forwarding of pending results
    always_comb begin
        MDU_Result = '0;
        if (op == OP_MFHI) MDU_Result = hi_q;
        else if (op == OP_MFLO) MDU_Result = lo_q;
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: table of operations with hand-computed
// results and latencies, plus directed sequences for Req, reset and MT paths.
module tb_mdu_ctrl;

    localparam logic [3:0] NONE  = 4'd0,  MULT  = 4'd1,  MULTU = 4'd2,
                           DIV   = 4'd3,  DIVU  = 4'd4,  MFHI  = 4'd5,
                           MFLO  = 4'd6,  MTHI  = 4'd7,  MTLO  = 4'd8,
                           MADD  = 4'd9,  MADDU = 4'd10, MSUB  = 4'd11,
                           BADOP = 4'd13;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Req;
    logic        Busy;
    logic [31:0] HI, LO, MDU_Result;

    int errors = 0;
    int checks = 0;

    mdu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .MDUOp      (MDUOp),
        .A          (A),
        .B          (B),
        .Req        (Req),
        .Busy       (Busy),
        .HI         (HI),
        .LO         (LO),
        .MDU_Result (MDU_Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] phi;
        logic [31:0] plo;
        int          busy;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; sample point is just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        MDUOp = op;
        A = val;
        step();
        MDUOp = NONE;
    endtask

    // Launch and count busy cycles (bounded)
    task automatic launch_and_wait(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output int n,
                                   output logic [31:0] last_hi);
        Start = 1'b1;
        MDUOp = op;
        A = a;
        B = b;
        step();
        Start = 1'b0;
        MDUOp = NONE;
        n = 0;
        last_hi = HI;
        while (Busy && n < 20) begin
            last_hi = HI;
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        logic [31:0] last_hi;

        vecs[0]  = '{MULT,  32'hFFFFFFFF, 32'h2,        32'h0,  32'h0,  5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'h2,        32'h0,  32'h0,  5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h2,        32'h0,  32'h0,  10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{DIVU,  32'h7,        32'h0,        32'h11, 32'h22, 10, 32'h11,       32'h22};
        vecs[4]  = '{DIV,   32'h7,        32'hFFFFFFFE, 32'h0,  32'h0,  10, 32'h1,        32'hFFFFFFFD};
        vecs[5]  = '{DIV,   32'hFFFFFFF9, 32'h0,        32'hAA, 32'hBB, 10, 32'hAA,       32'hBB};
        vecs[6]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  5,  32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,  5,  32'h40000000, 32'h0};
        vecs[8]  = '{DIVU,  32'd100,      32'd7,        32'h0,  32'h0,  10, 32'h2,        32'hE};
        vecs[9]  = '{DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,  32'h0,  10, 32'hF,        32'h0FFFFFFF};
        vecs[10] = '{BADOP, 32'h3,        32'h4,        32'h5,  32'h6,  0,  32'h5,        32'h6};
`ifdef MDU_MADD_EN
        vecs[11] = '{MADDU, 32'h1,        32'h1,        32'h0,  32'hFFFFFFFF, 5, 32'h1,   32'h0};
        vecs[12] = '{MADD,  32'hFFFFFFFF, 32'h3,        32'h0,  32'h5,  5,  32'h0,        32'h2};
        vecs[13] = '{MSUB,  32'h1,        32'h1,        32'h0,  32'h0,  5,  32'hFFFFFFFF, 32'hFFFFFFFF};
`else
        vecs[11] = '{MADDU, 32'h1,        32'h1,        32'h0,  32'hFFFFFFFF, 0, 32'h0,   32'hFFFFFFFF};
        vecs[12] = '{MADD,  32'hFFFFFFFF, 32'h3,        32'h0,  32'h5,  0,  32'h0,        32'h5};
        vecs[13] = '{MSUB,  32'h1,        32'h1,        32'h7,  32'h9,  0,  32'h7,        32'h9};
`endif

        reset = 1'b1; Start = 1'b0; MDUOp = NONE; A = '0; B = '0; Req = 1'b0;
        step(); step();
        reset = 1'b0;
        MDUOp = MFHI;
        #1;
        check("reset Busy", {31'b0, Busy}, 32'h0);
        check("reset HI", HI, 32'h0);
        check("reset LO", LO, 32'h0);
        check("reset MFHI", MDU_Result, 32'h0);
        MDUOp = NONE;
        step();

        // Table-driven operations
        for (int i = 0; i < NV; i++) begin
            mt(MTHI, vecs[i].phi);
            mt(MTLO, vecs[i].plo);
            launch_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, n, last_hi);
            check($sformatf("v%0d busy cycles", i), 32'(n), 32'(vecs[i].busy));
            check($sformatf("v%0d HI before commit", i), last_hi, vecs[i].phi);
            check($sformatf("v%0d HI", i), HI, vecs[i].ehi);
            check($sformatf("v%0d LO", i), LO, vecs[i].elo);
            MDUOp = MFHI; #1;
            check($sformatf("v%0d MFHI", i), MDU_Result, vecs[i].ehi);
            MDUOp = MFLO; #1;
            check($sformatf("v%0d MFLO", i), MDU_Result, vecs[i].elo);
            MDUOp = NONE;
            step();
        end

        // MTHI then MFHI next cycle, no Busy
        MDUOp = MTHI; A = 32'h1234;
        step();
        check("mthi Busy", {31'b0, Busy}, 32'h0);
        MDUOp = MFHI; #1;
        check("mthi MFHI", MDU_Result, 32'h1234);
        MDUOp = NONE;

        // MTLO blocked by Req
        mt(MTLO, 32'h0000BEEF);
        Req = 1'b1;
        mt(MTLO, 32'h0000CAFE);
        Req = 1'b0;
        check("mtlo Req LO", LO, 32'h0000BEEF);

        // Start div with Req: no launch, no later commit
        Start = 1'b1; MDUOp = DIV; A = 32'd100; B = 32'd3; Req = 1'b1;
        step();
        Start = 1'b0; MDUOp = NONE; Req = 1'b0;
        check("req start Busy", {31'b0, Busy}, 32'h0);
        for (int k = 0; k < 12; k++) step();
        check("req start HI", HI, 32'h1234);
        check("req start LO", LO, 32'h0000BEEF);

        // Operation in flight ignores MTHI
        Start = 1'b1; MDUOp = MULT; A = 32'd6; B = 32'd7;
        step();
        Start = 1'b0; MDUOp = NONE;
        step();
        MDUOp = MTHI; A = 32'hDEADDEAD;
        step();
        MDUOp = NONE;
        n = 2;
        while (Busy && n < 20) begin n++; step(); end
        check("busy-mthi cycles", 32'(n), 32'd5);
        check("busy-mthi HI", HI, 32'h0);
        check("busy-mthi LO", LO, 32'd42);

        // Reset mid-divide: cleared, never committed
        mt(MTHI, 32'h55);
        Start = 1'b1; MDUOp = DIV; A = 32'd100; B = 32'd3;
        step();
        Start = 1'b0; MDUOp = NONE;
        step(); step(); step();
        check("abort busy@4", {31'b0, Busy}, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort Busy", {31'b0, Busy}, 32'h0);
        check("abort HI", HI, 32'h0);
        check("abort LO", LO, 32'h0);
        for (int k = 0; k < 12; k++) step();
        check("abort late HI", HI, 32'h0);
        check("abort late LO", LO, 32'h0);
        check("abort late Busy", {31'b0, Busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
